// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch and a data requester.
// Optional macro ROUND_ROBIN_EN alternates grants on simultaneous requests; otherwise data wins.
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_holdn,
  output logic [DATA_W-1:0] i_data,
  output logic              i_mexc,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_holdn,
  output logic [DATA_W-1:0] d_data,
  output logic              d_mexc,
  output logic              d_werr,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_err,
  output logic              busy,
  output logic              owner_d
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic [7:0]        cnt;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              grant_d;
  logic              in_resp;

`ifdef ROUND_ROBIN_EN
  // last_d = 0 means the fetch port was served last, so data is preferred next
  logic last_d;
  assign grant_d = d_req && (!i_req || !last_d);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      owner_d <= 1'b1;
      rdata   <= '0;
      err     <= 1'b0;
      cnt     <= '0;
`ifdef ROUND_ROBIN_EN
      last_d  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner_d <= grant_d;
            m_we    <= grant_d ? d_we : 1'b0;
            m_addr  <= grant_d ? d_addr : i_addr;
            m_wdata <= grant_d ? d_wdata : '0;
            cnt     <= '0;
            state   <= ISSUE;
`ifdef ROUND_ROBIN_EN
            last_d  <= grant_d;
`endif
          end
        end
        ISSUE: begin
          if (m_ack) begin
            rdata <= m_rdata;
            err   <= m_err;
            cnt   <= '0;
            state <= RESP;
          end else if (cnt == TO_LAST) begin
            // No acknowledge within the budget: abandon and report an error
            rdata <= '0;
            err   <= 1'b1;
            cnt   <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_resp = (state == RESP);
  assign m_req   = (state == ISSUE);
  assign busy    = (state != IDLE);

  assign i_holdn = !(i_req && !(in_resp && !owner_d));
  assign d_holdn = !(d_req && !(in_resp && owner_d));

  assign i_data  = (in_resp && !owner_d) ? rdata : '0;
  assign d_data  = (in_resp && owner_d) ? rdata : '0;
  assign i_mexc  = in_resp && !owner_d && err;
  assign d_mexc  = in_resp && owner_d && !m_we && err;
  assign d_werr  = in_resp && owner_d && m_we && err;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (instance built with TIMEOUT=4).
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, m_ack, m_err;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic        i_holdn, i_mexc, d_holdn, d_mexc, d_werr;
  logic        m_req, m_we, busy, owner_d;
  logic [31:0] i_data, d_data, m_addr, m_wdata;

  int errors = 0;
  int checks = 0;
  int n;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_holdn(i_holdn), .i_data(i_data), .i_mexc(i_mexc),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_holdn(d_holdn), .d_data(d_data), .d_mexc(d_mexc), .d_werr(d_werr),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err),
    .busy(busy), .owner_d(owner_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; m_ack = 0; m_err = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
    #1;
    // Reset state, no clock edge yet
    check("rst_m_req", m_req, 0);
    check("rst_busy", busy, 0);
    check("rst_owner_d", owner_d, 1);
    check("rst_m_addr", m_addr, 0);
    check("rst_i_holdn", i_holdn, 1);
    d_req = 1; #1;
    check("rst_d_holdn_req", d_holdn, 0);
    d_req = 0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single fetch with minimum latency
    i_req = 1; i_addr = 32'h40; #1;
    check("f_holdn_c0", i_holdn, 0);
    tick();
    check("f_m_req", m_req, 1);
    check("f_m_addr", m_addr, 32'h40);
    check("f_m_we", m_we, 0);
    check("f_owner", owner_d, 0);
    check("f_busy", busy, 1);
    m_ack = 1; m_rdata = 32'h8E00C002; m_err = 0;
    tick();
    m_ack = 0;
    check("f_holdn_c2", i_holdn, 1);
    check("f_data", i_data, 32'h8E00C002);
    check("f_mexc", i_mexc, 0);
    check("f_m_req_resp", m_req, 0);
    i_req = 0;
    tick();
    check("f_data_idle", i_data, 0);
    check("f_busy_idle", busy, 0);

    // Data write that returns an error
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'h13;
    tick();
    check("w_m_we", m_we, 1);
    check("w_m_addr", m_addr, 32'h100);
    check("w_m_wdata", m_wdata, 32'h13);
    check("w_owner", owner_d, 1);
    check("w_holdn_issue", d_holdn, 0);
    m_ack = 1; m_err = 1;
    tick();
    m_ack = 0; m_err = 0;
    check("w_werr", d_werr, 1);
    check("w_holdn", d_holdn, 1);
    check("w_mexc", d_mexc, 0);
    d_req = 0; d_we = 0;
    tick();
    check("w_werr_after", d_werr, 0);

    // Fetch timeout: m_req must stay high for exactly 4 cycles
    i_req = 1; i_addr = 32'h80;
    tick();
    n = 0;
    for (int c = 0; c < 20 && m_req; c++) begin
      n++;
      tick();
    end
    check("to_cycles", n, 4);
    check("to_mexc", i_mexc, 1);
    check("to_holdn", i_holdn, 1);
    i_req = 0;
    tick();
    check("to_mexc_after", i_mexc, 0);
    check("to_busy_after", busy, 0);

    // Reset in the second ISSUE cycle, then a normal data read
    d_req = 1; d_addr = 32'h300;
    tick();
    tick();
    check("ri_m_req_before", m_req, 1);
    rst = 1'b1; #1;
    check("ri_m_req", m_req, 0);
    check("ri_busy", busy, 0);
    check("ri_owner", owner_d, 1);
    tick();
    check("ri_no_resp", d_data, 0);
    check("ri_holdn", d_holdn, 0);
    rst = 1'b0;
    tick();
    check("ri_issue", m_req, 1);
    m_ack = 1; m_rdata = 32'h55;
    tick();
    m_ack = 0;
    check("ri_d_data", d_data, 32'h55);
    check("ri_d_holdn", d_holdn, 1);
    check("ri_d_mexc", d_mexc, 0);
    d_req = 0;
    tick();

    // Simultaneous requests over four transactions, starting from a fresh reset
    rst = 1'b1; tick(); rst = 1'b0; tick();
    i_req = 1; d_req = 1; d_we = 0; i_addr = 32'h44; d_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      logic exp_d;
`ifdef ROUND_ROBIN_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      tick();
      check($sformatf("sim%0d_owner", k), owner_d, exp_d);
      check($sformatf("sim%0d_addr", k), m_addr, exp_d ? 32'h200 : 32'h44);
      m_ack = 1; m_rdata = 32'hA0 + k;
      tick();
      m_ack = 0;
      check($sformatf("sim%0d_win_holdn", k), exp_d ? d_holdn : i_holdn, 1);
      check($sformatf("sim%0d_lose_holdn", k), exp_d ? i_holdn : d_holdn, 0);
      check($sformatf("sim%0d_data", k), exp_d ? d_data : i_data, 32'hA0 + k);
      tick();
      check($sformatf("sim%0d_idle", k), busy, 0);
    end
    i_req = 0; d_req = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
